safe_attempt_ctrl: RTL and testbench

//  Sequencer for the digital-safe datapath. Takes N-bit code words from the keypad side,

---
 rtl/safe_attempt_ctrl.sv | 147 ++++++++++++++
 tb/tb_safe_attempt_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/safe_attempt_ctrl.sv
// Attempt sequencer for the digital safe: hands keypad code words to the p2s
// converter, waits for the lock verdict, and runs the door-open and lockout timers.
module safe_attempt_ctrl #(
  parameter int N           = 4,
  parameter int MAX_TRIES   = 3,
  parameter int VERDICT_TO  = 32,
  parameter int OPEN_CYC    = 8,
  parameter int LOCKOUT_CYC = 20
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           code_valid,
  input  logic [N-1:0]                   code_data,
  output logic                           code_ready,
  output logic                           pvalid,
  output logic [N-1:0]                   pdata,
  input  logic                           pready,
  input  logic                           unlock_valid,
  input  logic                           unlock,
  input  logic                           relock,
  output logic                           door_open,
  output logic                           alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

  localparam int FW     = $clog2(MAX_TRIES + 1);
  localparam int CMAX_A = (VERDICT_TO > OPEN_CYC) ? VERDICT_TO : OPEN_CYC;
  localparam int CMAX   = (CMAX_A > LOCKOUT_CYC) ? CMAX_A : LOCKOUT_CYC;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] VTO_LAST  = CW'(VERDICT_TO - 1);
  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYC - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_TRIES - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT    = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [N-1:0]  pdata_q, pdata_d;
  logic          code_ready_q, pvalid_q, door_open_q, alarm_q;

  // Next-state, shared cycle counter, failure count and latched code word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    pdata_d = pdata_q;
    case (state_q)
      S_IDLE: begin
        if (code_valid && code_ready_q) begin
          pdata_d = code_data;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (pready) begin
          state_d = S_WAIT;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        // A verdict on the timeout cycle takes priority over the timeout.
        if (unlock_valid && unlock) begin
          state_d = S_OPEN;
          fail_d  = {FW{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else if (unlock_valid || (cnt_q == VTO_LAST)) begin
          if (fail_q >= FAIL_LAST) begin
            state_d = S_LOCKOUT;
            fail_d  = FAIL_MAX;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = S_IDLE;
            fail_d  = fail_q + FW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OPEN: begin
        if (relock || (cnt_q == OPEN_LAST)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOCKOUT: begin
        if (cnt_q == LOCK_LAST) begin
          state_d = S_IDLE;
          fail_d  = {FW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
        fail_d  = {FW{1'b0}};
        pdata_d = {N{1'b0}};
      end
    endcase
  end

  // State registers; Moore flags are registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      fail_q       <= {FW{1'b0}};
      pdata_q      <= {N{1'b0}};
      code_ready_q <= 1'b1;
      pvalid_q     <= 1'b0;
      door_open_q  <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      pdata_q      <= pdata_d;
      code_ready_q <= (state_d == S_IDLE);
      pvalid_q     <= (state_d == S_SEND);
      door_open_q  <= (state_d == S_OPEN);
      alarm_q      <= (state_d == S_LOCKOUT);
    end
  end

  assign code_ready = code_ready_q;
  assign pvalid     = pvalid_q;
  assign pdata      = pdata_q;
  assign door_open  = door_open_q;
  assign alarm      = alarm_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_safe_attempt_ctrl.sv
// Directed bench for safe_attempt_ctrl at default parameters; expectations are hand-derived.
module tb_safe_attempt_ctrl;

  logic       clk;
  logic       rstn;
  logic       code_valid;
  logic [3:0] code_data;
  logic       code_ready;
  logic       pvalid;
  logic [3:0] pdata;
  logic       pready;
  logic       unlock_valid;
  logic       unlock;
  logic       relock;
  logic       door_open;
  logic       alarm;
  logic [1:0] fail_cnt;

  int errors = 0;
  int checks = 0;

  safe_attempt_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .code_valid   (code_valid),
    .code_data    (code_data),
    .code_ready   (code_ready),
    .pvalid       (pvalid),
    .pdata        (pdata),
    .pready       (pready),
    .unlock_valid (unlock_valid),
    .unlock       (unlock),
    .relock       (relock),
    .door_open    (door_open),
    .alarm        (alarm),
    .fail_cnt     (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic cr, input logic pv,
                           input logic dop, input logic al, input logic [1:0] fc);
    chk({tag, ".code_ready"}, {31'd0, code_ready}, {31'd0, cr});
    chk({tag, ".pvalid"},     {31'd0, pvalid},     {31'd0, pv});
    chk({tag, ".door_open"},  {31'd0, door_open},  {31'd0, dop});
    chk({tag, ".alarm"},      {31'd0, alarm},      {31'd0, al});
    chk({tag, ".fail_cnt"},   {30'd0, fail_cnt},   {30'd0, fc});
  endtask

  // Accept a word and push it through SEND with pready high; ends on the first WAIT cycle.
  task automatic send_code(input logic [3:0] d);
    code_valid = 1'b1;
    code_data  = d;
    pready     = 1'b1;
    tick();
    chk("send.pvalid", {31'd0, pvalid}, 32'd1);
    chk("send.pdata",  {28'd0, pdata},  {28'd0, d});
    code_valid = 1'b0;
    tick();
    chk("send.wait_pvalid", {31'd0, pvalid}, 32'd0);
  endtask

  task automatic verdict(input logic u);
    unlock_valid = 1'b1;
    unlock       = u;
    tick();
    unlock_valid = 1'b0;
    unlock       = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; code_valid = 1'b0; code_data = 4'h0; pready = 1'b0;
    unlock_valid = 1'b0; unlock = 1'b0; relock = 1'b0;
    tick();
    tick();
    chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset.pdata", {28'd0, pdata}, 32'd0);
    rstn = 1'b1;
    tick();
    chk_flags("idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // 1. correct code, verdict on the fifth WAIT cycle, door open for 8 cycles
    send_code(4'hA);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1.wait", {31'd0, door_open}, 32'd0);
    end
    verdict(1'b1);
    chk_flags("t1.open", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t1.door_held", {31'd0, door_open}, 32'd1);
    end
    tick();
    chk_flags("t1.closed", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // 2. backpressure holds pvalid/pdata for 6 cycles
    code_valid = 1'b1;
    code_data  = 4'hA;
    pready     = 1'b0;
    tick();
    code_valid = 1'b0;
    code_data  = 4'h5;
    for (int i = 0; i < 6; i++) begin
      chk("t2.pvalid", {31'd0, pvalid}, 32'd1);
      chk("t2.pdata",  {28'd0, pdata},  32'hA);
      tick();
    end
    chk("t2.still_send", {31'd0, pvalid}, 32'd1);
    pready = 1'b1;
    tick();
    chk("t2.wait_entered", {31'd0, pvalid}, 32'd0);

    // 3. three incorrect verdicts lead to lockout
    verdict(1'b0);
    chk_flags("t3.fail1", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    send_code(4'h3);
    verdict(1'b0);
    chk_flags("t3.fail2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    send_code(4'h5);
    verdict(1'b0);
    chk_flags("t3.lockout", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    code_valid = 1'b1;
    code_data  = 4'h7;
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("t3.alarm_held", {31'd0, alarm},      32'd1);
      chk("t3.stalled",    {31'd0, code_ready}, 32'd0);
    end
    code_valid = 1'b0;
    tick();
    chk_flags("t3.released", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // 4a. no verdict: timeout after 32 WAIT cycles
    send_code(4'h1);
    for (int i = 1; i < 32; i++) begin
      tick();
      chk("t4.waiting", {31'd0, code_ready}, 32'd0);
    end
    tick();
    chk_flags("t4.timeout", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

    // 4b. verdict on the timeout cycle wins
    send_code(4'h2);
    for (int i = 1; i < 32; i++) tick();
    verdict(1'b1);
    chk_flags("t4.late_open", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk_flags("t4.relock", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // 5. two failures then correct code; relock on OPEN cycle 3
    send_code(4'h6);
    verdict(1'b0);
    send_code(4'h7);
    verdict(1'b0);
    chk("t5.two_fails", {30'd0, fail_cnt}, 32'd2);
    send_code(4'h8);
    verdict(1'b1);
    chk_flags("t5.open", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    tick();
    chk("t5.cycle3", {31'd0, door_open}, 32'd1);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk_flags("t5.relocked", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // stray relock and verdict in IDLE are ignored
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk_flags("stray.relock", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    send_code(4'h9);
    verdict(1'b0);
    verdict(1'b0);
    chk_flags("stray.verdict", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

    // 6a. asynchronous reset in WAIT
    send_code(4'hC);
    #2 rstn = 1'b0;
    #1;
    chk_flags("t6.rst_wait", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t6.rst_wait.pdata", {28'd0, pdata}, 32'd0);
    tick();
    rstn = 1'b1;
    unlock_valid = 1'b1;
    unlock       = 1'b1;
    tick();
    unlock_valid = 1'b0;
    unlock       = 1'b0;
    chk_flags("t6.stray_unlock", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // 6b. asynchronous reset in LOCKOUT
    send_code(4'h1);
    verdict(1'b0);
    send_code(4'h2);
    verdict(1'b0);
    send_code(4'h3);
    verdict(1'b0);
    tick();
    tick();
    chk_flags("t6.in_lockout", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    #2 rstn = 1'b0;
    #1;
    chk_flags("t6.rst_lockout", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk_flags("t6.after", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
